// File: rtl/mu0_mem_arbiter_if.sv
// Bus bundle between the MU0 memory arbiter and its core, host
// and memory neighbours.
interface mu0_mem_arbiter_if;
    logic        c_req;
    logic        c_rnw;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic        c_ack;
    logic [15:0] c_rdata;

    logic        h_req;
    logic        h_rnw;
    logic [15:0] h_addr;
    logic [15:0] h_wdata;
    logic        h_ack;
    logic [15:0] h_rdata;
    logic        host_lock;

    logic        mem_rq;
    logic        mem_rnw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        core_stalled;

    modport slave (
        input  c_req, c_rnw, c_addr, c_wdata,
        input  h_req, h_rnw, h_addr, h_wdata, host_lock,
        input  mem_rdata,
        output c_ack, c_rdata, h_ack, h_rdata,
        output mem_rq, mem_rnw, mem_addr, mem_wdata,
        output core_stalled
    );

    modport master (
        output c_req, c_rnw, c_addr, c_wdata,
        output h_req, h_rnw, h_addr, h_wdata, host_lock,
        output mem_rdata,
        input  c_ack, c_rdata, h_ack, h_rdata,
        input  mem_rq, mem_rnw, mem_addr, mem_wdata,
        input  core_stalled
    );
endinterface

// File: rtl/mu0_mem_arbiter.sv
// Shares one single-port memory between the MU0 core and a host
// port; host has priority but is limited to HOST_BURST grants.
module mu0_mem_arbiter #(
    parameter int unsigned HOST_BURST = 4,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    mu0_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] BURST_MAX = 4'(HOST_BURST);
    localparam logic [1:0] LAT_INIT  = 2'(MEM_LAT);

    state_t      state_q, state_d;
    logic        win_core_q, win_core_d;
    logic [3:0]  burst_q, burst_d;
    logic [1:0]  lat_q, lat_d;
    logic        mem_rq_q, mem_rq_d;
    logic        mem_rnw_q, mem_rnw_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        c_ack_q, c_ack_d;
    logic        h_ack_q, h_ack_d;
    logic [15:0] c_rdata_q, c_rdata_d;
    logic [15:0] h_rdata_q, h_rdata_d;
    logic        stall_q, stall_d;

    logic        core_elig;
    logic        host_elig;
    logic        pick_core;

    // Pick a winner; core wins only alone or once the host burst is spent.
    always_comb begin
        core_elig = bus.c_req & ~bus.host_lock;
        host_elig = bus.h_req;
        pick_core = core_elig & (~host_elig | (burst_q == BURST_MAX));
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        win_core_d  = win_core_q;
        burst_d     = burst_q;
        lat_d       = lat_q;
        mem_rq_d    = 1'b0;
        mem_rnw_d   = mem_rnw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        c_ack_d     = 1'b0;
        h_ack_d     = 1'b0;
        c_rdata_d   = c_rdata_q;
        h_rdata_d   = h_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (core_elig | host_elig) begin
                    state_d    = ISSUE;
                    mem_rq_d   = 1'b1;
                    win_core_d = pick_core;
                    if (pick_core) begin
                        mem_rnw_d   = bus.c_rnw;
                        mem_addr_d  = bus.c_addr;
                        mem_wdata_d = bus.c_wdata;
                        burst_d     = 4'd0;
                    end else begin
                        mem_rnw_d   = bus.h_rnw;
                        mem_addr_d  = bus.h_addr;
                        mem_wdata_d = bus.h_wdata;
                        if (!bus.host_lock) begin
                            burst_d = bus.c_req ? burst_q + 4'd1 : 4'd0;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_INIT;
            end
            WAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd1) begin
                    state_d = ACK;
                    c_ack_d = win_core_q;
                    h_ack_d = ~win_core_q;
                    if (mem_rnw_q) begin
                        if (win_core_q) begin
                            c_rdata_d = bus.mem_rdata;
                        end else begin
                            h_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        stall_d = bus.c_req & ~((state_d != IDLE) & win_core_d);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            win_core_q  <= 1'b0;
            burst_q     <= 4'd0;
            lat_q       <= 2'd0;
            mem_rq_q    <= 1'b0;
            mem_rnw_q   <= 1'b1;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
            c_ack_q     <= 1'b0;
            h_ack_q     <= 1'b0;
            c_rdata_q   <= 16'd0;
            h_rdata_q   <= 16'd0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_core_q  <= win_core_d;
            burst_q     <= burst_d;
            lat_q       <= lat_d;
            mem_rq_q    <= mem_rq_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            c_ack_q     <= c_ack_d;
            h_ack_q     <= h_ack_d;
            c_rdata_q   <= c_rdata_d;
            h_rdata_q   <= h_rdata_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.mem_rq       = mem_rq_q;
    assign bus.mem_rnw      = mem_rnw_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.c_ack        = c_ack_q;
    assign bus.h_ack        = h_ack_q;
    assign bus.c_rdata      = c_rdata_q;
    assign bus.h_rdata      = h_rdata_q;
    assign bus.core_stalled = stall_q;
endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: two instances (MEM_LAT 1 and 3), memory
// models returning junk outside the sample cycle, ack scoreboards.
module tb_mu0_mem_arbiter;
    typedef struct packed {
        logic        core;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n;
    int   last;
    int   t0;

    exp_t        sb1[$];
    exp_t        sb3[$];
    logic [15:0] ecr[2];
    logic [15:0] ehr[2];

    logic [15:0] wr1[256];
    bit          wv1[256];
    logic [15:0] wr3[256];
    bit          wv3[256];
    bit          pend1, pend3;
    int          k1, k3;
    logic [7:0]  a1, a3;

    mu0_mem_arbiter_if bus1 ();
    mu0_mem_arbiter_if bus3 ();

    mu0_mem_arbiter #(.HOST_BURST(4), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    mu0_mem_arbiter #(.HOST_BURST(4), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h0005) ? 16'h1234 : {a[7:0], ~a[7:0]};
    endfunction

    // Memory for the MEM_LAT=1 instance: valid data only in sample cycle.
    always @(negedge clk) begin
        if (!reset_n) pend1 = 1'b0;
        else if (bus1.mem_rq) begin
            pend1 = 1'b1; k1 = 0; a1 = bus1.mem_addr[7:0];
            if (!bus1.mem_rnw) begin
                wr1[a1] = bus1.mem_wdata; wv1[a1] = 1'b1;
            end
        end else if (pend1) k1++;
        if (pend1 && k1 == 1) begin
            bus1.mem_rdata = wv1[a1] ? wr1[a1] : init_word({8'h00, a1});
            pend1 = 1'b0;
        end else bus1.mem_rdata = 16'($urandom);
    end

    // Memory for the MEM_LAT=3 instance.
    always @(negedge clk) begin
        if (!reset_n) pend3 = 1'b0;
        else if (bus3.mem_rq) begin
            pend3 = 1'b1; k3 = 0; a3 = bus3.mem_addr[7:0];
            if (!bus3.mem_rnw) begin
                wr3[a3] = bus3.mem_wdata; wv3[a3] = 1'b1;
            end
        end else if (pend3) k3++;
        if (pend3 && k3 == 3) begin
            bus3.mem_rdata = wv3[a3] ? wr3[a3] : init_word({8'h00, a3});
            pend3 = 1'b0;
        end else bus3.mem_rdata = 16'($urandom);
    end

    task automatic mon(input bit d3);
        logic ca, ha;
        logic [15:0] cr, hr;
        exp_t e;
        ca = d3 ? bus3.c_ack : bus1.c_ack;
        ha = d3 ? bus3.h_ack : bus1.h_ack;
        cr = d3 ? bus3.c_rdata : bus1.c_rdata;
        hr = d3 ? bus3.h_rdata : bus1.h_rdata;
        if (ca | ha) begin
            if ((d3 ? sb3.size() : sb1.size()) == 0) begin
                check("spurious_ack", {ca, ha}, 2'b00);
            end else begin
                e = d3 ? sb3.pop_front() : sb1.pop_front();
                check("ack_who", {ca, ha}, e.core ? 2'b10 : 2'b01);
                if (e.rd && e.core) ecr[d3] = e.data;
                if (e.rd && !e.core) ehr[d3] = e.data;
                check("c_rdata", cr, ecr[d3]);
                check("h_rdata", hr, ehr[d3]);
            end
        end
    endtask

    // Scoreboards: every ack pops one expected grant.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb1.delete(); sb3.delete();
            ecr[0] = 16'd0; ecr[1] = 16'd0;
            ehr[0] = 16'd0; ehr[1] = 16'd0;
        end else begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    task automatic drive(input bit d3, input bit core, input bit req,
                         input bit rnw, input logic [15:0] addr,
                         input logic [15:0] wdata);
        if (d3 && core) begin
            bus3.c_req = req; bus3.c_rnw = rnw;
            bus3.c_addr = addr; bus3.c_wdata = wdata;
        end else if (d3) begin
            bus3.h_req = req; bus3.h_rnw = rnw;
            bus3.h_addr = addr; bus3.h_wdata = wdata;
        end else if (core) begin
            bus1.c_req = req; bus1.c_rnw = rnw;
            bus1.c_addr = addr; bus1.c_wdata = wdata;
        end else begin
            bus1.h_req = req; bus1.h_rnw = rnw;
            bus1.h_addr = addr; bus1.h_wdata = wdata;
        end
    endtask

    function automatic logic ack_of(input bit d3, input bit core);
        if (d3) return core ? bus3.c_ack : bus3.h_ack;
        return core ? bus1.c_ack : bus1.h_ack;
    endfunction

    function automatic logic [33:0] mreq(input bit d3);
        if (d3) return {bus3.mem_rq, bus3.mem_rnw, bus3.mem_addr, bus3.mem_wdata};
        return {bus1.mem_rq, bus1.mem_rnw, bus1.mem_addr, bus1.mem_wdata};
    endfunction

    // One isolated access: request at IDLE cycle t, pulse at t+1, ack at t+LAT+2.
    task automatic acc(input bit d3, input bit core, input bit rnw,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd);
        int lat;
        int s;
        bit got;
        logic [33:0] m;
        lat = d3 ? 3 : 1;
        @(negedge clk);
        if (d3) sb3.push_back('{core: core, rd: rnw, data: exp_rd});
        else sb1.push_back('{core: core, rd: rnw, data: exp_rd});
        drive(d3, core, 1'b1, rnw, addr, wdata);
        s = cyc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            m = mreq(d3);
            if (cyc == s + 1) begin
                check("mem_rq", {31'd0, m[33]}, 1);
                check("mem_rnw", {31'd0, m[32]}, {31'd0, rnw});
                check("mem_addr", {16'd0, m[31:16]}, {16'd0, addr});
                if (!rnw) check("mem_wdata", {16'd0, m[15:0]}, {16'd0, wdata});
            end
            if (cyc == s + 2) check("rq_pulse", {31'd0, m[33]}, 0);
            if (ack_of(d3, core)) begin
                got = 1'b1;
                check("ack_lat", cyc - s, lat + 2);
            end
        end
        check("ack_seen", {31'd0, got}, 1);
        drive(d3, core, 1'b0, rnw, addr, wdata);
    endtask

    initial begin
        reset_n = 1'b0;
        bus1.host_lock = 1'b0;
        bus3.host_lock = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d[0], 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
            drive(d[0], 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        end
        repeat (2) @(negedge clk);
        check("rst_mem_rq", {31'd0, bus1.mem_rq}, 0);
        check("rst_c_ack", {31'd0, bus1.c_ack}, 0);
        check("rst_h_ack", {31'd0, bus1.h_ack}, 0);
        check("rst_stall", {31'd0, bus1.core_stalled}, 0);
        check("rst_mem_rnw", {31'd0, bus1.mem_rnw}, 1);
        check("rst_mem_addr", {16'd0, bus1.mem_addr}, 0);
        check("rst_mem_wdata", {16'd0, bus1.mem_wdata}, 0);
        check("rst_c_rdata", {16'd0, bus1.c_rdata}, 0);
        check("rst_h_rdata", {16'd0, bus1.h_rdata}, 0);
        reset_n = 1'b1;

        acc(0, 1, 1, 16'h0005, 16'h0000, 16'h1234);
        acc(0, 0, 0, 16'h0010, 16'hBEEF, 16'h0000);
        acc(0, 0, 1, 16'h0010, 16'h0000, 16'hBEEF);
        acc(0, 1, 0, 16'h0021, 16'h5555, 16'h0000);
        acc(0, 1, 1, 16'h0021, 16'h0000, 16'h5555);
        acc(0, 0, 1, 16'h0022, 16'h0000, init_word(16'h0022));

        // Both held: H,H,H,H,C repeating, one access every 4 cycles.
        @(negedge clk);
        for (int i = 0; i < 10; i++)
            sb1.push_back('{core: (i % 5 == 4), rd: 1'b1,
                data: (i % 5 == 4) ? init_word(16'h0020) : init_word(16'h0030)});
        drive(0, 1, 1, 1, 16'h0020, 16'h0000);
        drive(0, 0, 1, 1, 16'h0030, 16'h0000);
        n = 0; last = 0;
        for (int i = 0; i < 80 && n < 10; i++) begin
            @(negedge clk);
            if (bus1.c_ack || bus1.h_ack) begin
                if (n > 0) check("period", cyc - last, 4);
                last = cyc; n++;
            end
        end
        check("burst_acks", n, 10);
        drive(0, 1, 0, 1, 16'h0020, 16'h0000);
        drive(0, 0, 0, 1, 16'h0030, 16'h0000);

        // Host lock: core starved; lock dropped mid host access.
        @(negedge clk);
        bus1.host_lock = 1'b1;
        for (int i = 0; i < 4; i++)
            sb1.push_back('{core: (i == 3), rd: 1'b1,
                data: (i == 3) ? init_word(16'h0020) : init_word(16'h0030)});
        drive(0, 1, 1, 1, 16'h0020, 16'h0000);
        drive(0, 0, 1, 1, 16'h0030, 16'h0000);
        n = 0; last = cyc;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            if (n < 3) check("stalled", {31'd0, bus1.core_stalled}, 1);
            if (n == 2 && cyc == last + 2) begin
                check("lock_rq", {31'd0, bus1.mem_rq}, 1);
                bus1.host_lock = 1'b0;
            end
            if (bus1.h_ack) begin
                n++; last = cyc;
                if (n == 3) drive(0, 0, 0, 1, 16'h0030, 16'h0000);
            end else if (bus1.c_ack) begin
                check("core_slot", cyc - last, 4);
                n++;
                drive(0, 1, 0, 1, 16'h0020, 16'h0000);
            end
        end
        check("lock_acks", n, 4);

        // Reset while a core read is being issued.
        @(negedge clk);
        sb1.push_back('{core: 1'b1, rd: 1'b1, data: 16'h1234});
        drive(0, 1, 1, 1, 16'h0005, 16'h0000);
        @(negedge clk);
        check("rq_before_rst", {31'd0, bus1.mem_rq}, 1);
        reset_n = 1'b0;
        drive(0, 1, 0, 1, 16'h0005, 16'h0000);
        #1;
        check("rst_rq_drop", {31'd0, bus1.mem_rq}, 0);
        check("rst_rnw", {31'd0, bus1.mem_rnw}, 1);
        check("rst_crd", {16'd0, bus1.c_rdata}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_ack_after_rst", {30'd0, bus1.c_ack, bus1.h_ack}, 0);
        end

        // MEM_LAT=3 instance: ack at t+5, junk data around sample edge.
        acc(1, 1, 1, 16'h0040, 16'h0000, init_word(16'h0040));
        acc(1, 0, 0, 16'h0041, 16'h7777, 16'h0000);
        acc(1, 0, 1, 16'h0041, 16'h0000, 16'h7777);
        acc(1, 1, 1, 16'h0042, 16'h0000, init_word(16'h0042));
        acc(1, 0, 1, 16'h0043, 16'h0000, init_word(16'h0043));

        // Reset during the WAIT of a core read on the MEM_LAT=3 instance.
        @(negedge clk);
        sb3.push_back('{core: 1'b1, rd: 1'b1, data: init_word(16'h0044)});
        drive(1, 1, 1, 1, 16'h0044, 16'h0000);
        t0 = cyc;
        repeat (3) @(negedge clk);
        check("wait_cyc", cyc - t0, 3);
        reset_n = 1'b0;
        drive(1, 1, 0, 1, 16'h0044, 16'h0000);
        #1;
        check("rst3_rq", {31'd0, bus3.mem_rq}, 0);
        check("rst3_crd", {16'd0, bus3.c_rdata}, 0);
        check("rst3_hrd", {16'd0, bus3.h_rdata}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("no_ack3_after_rst", {30'd0, bus3.c_ack, bus3.h_ack}, 0);
        end
        check("crd3_kept", {16'd0, bus3.c_rdata}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mu0_mem_arbiter.md
MU0_MEM_ARBITER -- requirements
Module: mu0_mem_arbiter

Interface
REQ-001 SHALL have parameter HOST_BURST, default 4, max consecutive host grants while core waits (range 1..15).
REQ-002 SHALL have parameter MEM_LAT, default 1, cycles from mem_rq to valid mem_rdata (range 1..3).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have these core-side ports:
- c_req  in  1  core access request.
- c_rnw  in  1  core 1=read 0=write.
- c_addr  in  16  core word address.
- c_wdata  in  16  core write data.
- c_ack  out  1  core access complete, 1-cycle pulse.
- c_rdata  out  16  core read data.
REQ-005 SHALL have these host-side ports:
- h_req  in  1  host (loader/debug) request.
- h_rnw  in  1  host 1=read 0=write.
- h_addr  in  16  host word address.
- h_wdata  in  16  host write data.
- h_ack  out  1  host access complete, 1-cycle pulse.
- h_rdata  out  16  host read data.
- host_lock  in  1  host exclusive; core never granted.
REQ-006 SHALL have these memory-side and status ports:
- mem_rq  out  1  memory request, 1-cycle pulse.
- mem_rnw  out  1  memory 1=read 0=write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- core_stalled  out  1  high while c_req pending and not in service.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK; all outputs registered.
REQ-008 IDLE: if any eligible request, SHALL pick winner, latch its rnw/addr/wdata into mem_rnw/mem_addr/mem_wdata, go ISSUE; else stay IDLE.
REQ-009 ISSUE: SHALL assert mem_rq for exactly this cycle, load latency counter with MEM_LAT, go WAIT.
REQ-010 WAIT: SHALL decrement counter; when it reaches 0, capture mem_rdata into winner's rdata register (reads only), go ACK.
REQ-011 ACK: SHALL pulse winner's ack for one cycle, go IDLE; the loser's rdata is unchanged.
REQ-012 Latency: request seen in IDLE at cycle t SHALL produce ack at cycle t+MEM_LAT+2; throughput one access per MEM_LAT+3 cycles.
REQ-013 Requesters hold req and fields stable until ack and drop req the cycle after ack; the arbiter SHALL ignore the acked requester's req during the ACK cycle.
REQ-014 Arbitration when only one requester is eligible: that requester SHALL win.
REQ-015 Arbitration on simultaneous requests, host_lock=0: host SHALL win unless burst_cnt==HOST_BURST, in which case core SHALL win.
REQ-016 burst_cnt (4-bit) SHALL update per grant:
- increment on host grant while c_req=1;
- clear on any core grant;
- clear on a host grant while c_req=0.
REQ-017 host_lock=1 SHALL make core ineligible, with burst_cnt frozen.
REQ-018 A host_lock change mid-access SHALL NOT abort the in-flight access.
REQ-019 core_stalled SHALL equal c_req & ~(core in service: ISSUE/WAIT/ACK with core winner).
REQ-020 Writes SHALL capture no rdata; their ack timing is identical to reads.

Reset
REQ-021 reset_n low SHALL asynchronously force:
- state IDLE;
- mem_rq, c_ack, h_ack, core_stalled to 0;
- mem_rnw to 1;
- mem_addr, mem_wdata, c_rdata, h_rdata, burst_cnt, latency counter to 0.
REQ-022 Reset mid-access SHALL drop the access: no ack is issued after reset release; mem_rq deasserts immediately.
REQ-023 First grant SHALL be evaluated on the first rising edge after reset_n deassertion.

Verification
REQ-024 Core read: MEM_LAT=1, mem[0x0005]=0x1234, c_req read 0x0005 at t -> mem_rq at t+1 with addr 0x0005, c_ack at t+3, c_rdata=0x1234.
REQ-025 Host write: h_req write 0x0010 data 0xBEEF -> mem_rq=1, mem_rnw=0, mem_wdata=0xBEEF for one cycle; h_ack after 3 cycles; c_rdata and h_rdata unchanged.
REQ-026 Burst fairness: HOST_BURST=4, c_req and h_req held continuously -> grant order H,H,H,H,C,H,H,H,H,C.
REQ-027 host_lock=1 with c_req and h_req held -> host served every access, core_stalled=1 throughout, c_ack never pulses; drop host_lock -> core served within one access slot.
REQ-028 Reset during WAIT of a core read -> mem_rq=0 immediately, no c_ack after release, state IDLE, c_rdata=0.
REQ-029 MEM_LAT=3 sweep: ack at t+5; mem_rdata changed at cycles other than the sample edge does not corrupt rdata.
